// File: rtl/mlp_pkg.sv
// Shared constants and types for the MLP output write-back path.
package mlp_pkg;
  localparam int NUM_CLASS_DEF  = 10;
  localparam int IN_IMG_NUM_DEF = 10;
  localparam int DATA_W_DEF     = 32;
  localparam int Y_ADDR_STRIDE  = 4;
  localparam int Y_ADDR_SHIFT   = $clog2(Y_ADDR_STRIDE);

  typedef enum logic [1:0] {WB_IDLE, WB_RUN, WB_DONE} wb_state_t;

  typedef logic signed [DATA_W_DEF-1:0] score_t;
endpackage

// File: rtl/argmax_tracker.sv
// Per-image signed argmax of a score stream; ties keep the lowest index.
// Only present in builds with WB_ARGMAX_EN defined.
`ifdef WB_ARGMAX_EN
module argmax_tracker
  import mlp_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int NUM_CLASS = NUM_CLASS_DEF,
  parameter int IDX_W     = $clog2(NUM_CLASS)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic signed [DATA_W-1:0] score_i,
  input  logic                     valid_i,
  input  logic                     first_i,
  input  logic                     last_i,
  output logic [IDX_W-1:0]         index_o,
  output logic                     valid_o
);
  logic signed [DATA_W-1:0] best_reg, best_next;
  logic [IDX_W-1:0]         best_idx_reg, best_idx_next;
  logic [IDX_W-1:0]         pos_reg, pos_next;
  logic [IDX_W-1:0]         index_reg;
  logic                     valid_reg;
  logic                     take;

  always_comb begin
    pos_next      = first_i ? '0 : pos_reg + IDX_W'(1);
    // strict greater-than so an equal later score never displaces the earlier one
    take          = first_i || (score_i > best_reg);
    best_next     = take ? score_i : best_reg;
    best_idx_next = take ? pos_next : best_idx_reg;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      best_reg     <= '0;
      best_idx_reg <= '0;
      pos_reg      <= '0;
      index_reg    <= '0;
      valid_reg    <= 1'b0;
    end else begin
      valid_reg <= valid_i && last_i;
      if (valid_i) begin
        best_reg     <= best_next;
        best_idx_reg <= best_idx_next;
        pos_reg      <= pos_next;
        if (last_i) index_reg <= best_idx_next;
      end
    end
  end

  assign index_o = index_reg;
  assign valid_o = valid_reg;
endmodule
`endif

// File: rtl/y_buf_wb_ctrl.sv
// Write-back scheduler: score stream -> y_buf writes, class/image counting, done signalling.
// Optional argmax prediction outputs are built when WB_ARGMAX_EN is defined.
module y_buf_wb_ctrl
  import mlp_pkg::*;
#(
  parameter int IN_IMG_NUM = IN_IMG_NUM_DEF,
  parameter int NUM_CLASS  = NUM_CLASS_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic                             res_valid_i,
  output logic                             res_ready_o,
  input  logic [DATA_W-1:0]                res_data_i,
  input  logic                             res_last_i,
  output logic                             y_buf_en,
  output logic                             y_buf_wr_en,
  output logic [ADDR_W-1:0]                y_buf_addr,
  output logic [DATA_W-1:0]                y_buf_data,
  output logic                             busy_o,
  output logic [$clog2(IN_IMG_NUM+1)-1:0]  img_cnt_o,
  output logic                             err_o,
  output logic                             done_intr_o,
  output logic                             done_led_o
`ifdef WB_ARGMAX_EN
  ,
  output logic [$clog2(NUM_CLASS)-1:0]     pred_o,
  output logic                             pred_valid_o
`endif
);
  localparam int TOTAL  = IN_IMG_NUM * NUM_CLASS;
  localparam int WIDX_W = $clog2(TOTAL);
  localparam int CLS_W  = $clog2(NUM_CLASS);
  localparam int IMG_W  = $clog2(IN_IMG_NUM + 1);

  wb_state_t         state_reg;
  logic [WIDX_W-1:0] word_idx_reg;
  logic [CLS_W-1:0]  class_cnt_reg;
  logic [IMG_W-1:0]  img_cnt_reg;
  logic              err_reg;
  logic              wr_pending_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] data_reg;
  logic              final_pend_reg;
  logic              done_intr_reg;
  logic              done_led_reg;

  logic hs, class_end, img_end, last_word, start_accept;

  assign res_ready_o  = (state_reg == WB_RUN);
  assign hs           = res_valid_i && res_ready_o;
  assign class_end    = (class_cnt_reg == CLS_W'(NUM_CLASS - 1));
  assign img_end      = res_last_i || class_end;
  assign last_word    = (word_idx_reg == WIDX_W'(TOTAL - 1));
  assign start_accept = start_i && (state_reg != WB_RUN);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= WB_IDLE;
      word_idx_reg   <= '0;
      class_cnt_reg  <= '0;
      img_cnt_reg    <= '0;
      err_reg        <= 1'b0;
      wr_pending_reg <= 1'b0;
      addr_reg       <= '0;
      data_reg       <= '0;
      final_pend_reg <= 1'b0;
      done_intr_reg  <= 1'b0;
      done_led_reg   <= 1'b0;
    end else begin
      wr_pending_reg <= hs;
      // done fires one cycle after the final write strobe
      final_pend_reg <= hs && last_word;
      done_intr_reg  <= final_pend_reg;
      if (final_pend_reg) done_led_reg <= 1'b1;
      if (hs) begin
        addr_reg <= ADDR_W'(word_idx_reg) << Y_ADDR_SHIFT;
        data_reg <= res_data_i;
      end
      case (state_reg)
        WB_IDLE, WB_DONE: begin
          if (start_i) begin
            state_reg     <= WB_RUN;
            word_idx_reg  <= '0;
            class_cnt_reg <= '0;
            img_cnt_reg   <= '0;
            err_reg       <= 1'b0;
            done_led_reg  <= 1'b0;
          end
        end
        WB_RUN: begin
          if (hs) begin
            if (res_last_i != class_end) err_reg <= 1'b1;
            class_cnt_reg <= img_end ? '0 : class_cnt_reg + CLS_W'(1);
            if (img_end && img_cnt_reg != IMG_W'(IN_IMG_NUM))
              img_cnt_reg <= img_cnt_reg + IMG_W'(1);
            if (last_word) begin
              state_reg    <= WB_DONE;
              word_idx_reg <= '0;
            end else begin
              word_idx_reg <= word_idx_reg + WIDX_W'(1);
            end
          end
        end
        default: state_reg <= WB_IDLE;
      endcase
    end
  end

  assign y_buf_en    = wr_pending_reg;
  assign y_buf_wr_en = wr_pending_reg;
  assign y_buf_addr  = addr_reg;
  assign y_buf_data  = data_reg;
  assign busy_o      = (state_reg == WB_RUN) || wr_pending_reg;
  assign img_cnt_o   = img_cnt_reg;
  assign err_o       = err_reg;
  assign done_intr_o = done_intr_reg;
  assign done_led_o  = done_led_reg;

`ifdef WB_ARGMAX_EN
  argmax_tracker #(
    .DATA_W    (DATA_W),
    .NUM_CLASS (NUM_CLASS)
  ) u_argmax (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (start_accept),
    .score_i (res_data_i),
    .valid_i (hs),
    .first_i (class_cnt_reg == '0),
    .last_i  (img_end),
    .index_o (pred_o),
    .valid_o (pred_valid_o)
  );
`else
  logic unused_start_accept;
  assign unused_start_accept = start_accept;
`endif
endmodule

// File: tb/tb_y_buf_wb_ctrl.sv
// Scoreboard bench for y_buf_wb_ctrl: expected writes queued at handshake, checked at strobe.
`timescale 1ns/1ps
module tb_y_buf_wb_ctrl;
  localparam int NI    = 10;
  localparam int NC    = 10;
  localparam int TOTAL = NI * NC;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, res_valid_i, res_last_i;
  logic [31:0] res_data_i;
  logic        res_ready_o, y_buf_en, y_buf_wr_en, busy_o, err_o, done_intr_o, done_led_o;
  logic [31:0] y_buf_addr, y_buf_data;
  logic [3:0]  img_cnt_o;
`ifdef WB_ARGMAX_EN
  logic [3:0]  pred_o;
  logic        pred_valid_o;
`endif

  always #5 clk_i = ~clk_i;

  y_buf_wb_ctrl #(.IN_IMG_NUM(NI), .NUM_CLASS(NC), .DATA_W(32), .ADDR_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .res_valid_i(res_valid_i), .res_ready_o(res_ready_o),
    .res_data_i(res_data_i), .res_last_i(res_last_i),
    .y_buf_en(y_buf_en), .y_buf_wr_en(y_buf_wr_en),
    .y_buf_addr(y_buf_addr), .y_buf_data(y_buf_data),
    .busy_o(busy_o), .img_cnt_o(img_cnt_o), .err_o(err_o),
    .done_intr_o(done_intr_o), .done_led_o(done_led_o)
`ifdef WB_ARGMAX_EN
    , .pred_o(pred_o), .pred_valid_o(pred_valid_o)
`endif
  );

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t exp_q[$];

  int checks = 0, errors = 0;
  int cyc = 0, strobes = 0, done_cnt = 0, done_cyc = 0;
  int first_wr_cyc = 0, last_wr_cyc = 0;

  // Negedge sample of the current cycle: scoreboard pop for any write strobe.
  task automatic sample();
    wr_t e;
    @(negedge clk_i);
    cyc++;
    if (y_buf_wr_en === 1'b1) begin
      strobes++;
      $display("wr cyc=%0d addr=%0d data=%08h", cyc, y_buf_addr, y_buf_data);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_write addr=%0d data=%08h required no write", y_buf_addr, y_buf_data);
      end else begin
        e = exp_q.pop_front();
        if (y_buf_addr !== e.addr || y_buf_data !== e.data || y_buf_en !== 1'b1) begin
          errors++;
          $display("FAIL sb_write addr=%0d data=%08h en=%b required addr=%0d data=%08h en=1",
                   y_buf_addr, y_buf_data, y_buf_en, e.addr, e.data);
        end
        if (e.addr == 32'd0) first_wr_cyc = cyc;
        if (e.addr == 32'(4 * (TOTAL - 1))) last_wr_cyc = cyc;
      end
    end
    if (done_intr_o === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic adv();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin sample(); adv(); end
  endtask

  task automatic do_start();
    start_i = 1'b1;
    sample(); adv();
    start_i = 1'b0;
    checks++;
    if (res_ready_o !== 1'b1 || done_led_o !== 1'b0) begin
      errors++;
      $display("FAIL start ready=%b led=%b required ready=1 led=0", res_ready_o, done_led_o);
    end
  endtask

  task automatic send_word(input int idx, input logic [31:0] d, input logic last);
    wr_t e;
    res_valid_i = 1'b1; res_data_i = d; res_last_i = last;
    sample();
    checks++;
    if (res_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL ready_in_run idx=%0d got=%b required=1", idx, res_ready_o);
    end
    e.addr = 32'(idx * 4); e.data = d;
    exp_q.push_back(e);
    adv();
    res_valid_i = 1'b0; res_last_i = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit && exp_q.size() != 0; i++) begin sample(); adv(); end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    idle(3);
  endtask

  task automatic check_batch_end(input string name, input int base, input logic exp_err);
    checks++;
    if (strobes - base != TOTAL || done_cnt != 1 || done_cyc != last_wr_cyc + 1) begin
      errors++;
      $display("FAIL %s_done strobes=%0d done_cnt=%0d done_cyc=%0d last_wr_cyc=%0d required strobes=%0d done_cnt=1 done_cyc=last_wr_cyc+1",
               name, strobes - base, done_cnt, done_cyc, last_wr_cyc, TOTAL);
    end
    checks++;
    if (done_led_o !== 1'b1 || img_cnt_o !== 4'(NI) || err_o !== exp_err || res_ready_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_status led=%b img=%0d err=%b ready=%b busy=%b required led=1 img=%0d err=%b ready=0 busy=0",
               name, done_led_o, img_cnt_o, err_o, res_ready_o, busy_o, NI, exp_err);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1; res_valid_i = 1'b0; start_i = 1'b0;
    sample(); adv();
    rst_i = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({y_buf_en, y_buf_wr_en, res_ready_o, busy_o, err_o, done_intr_o, done_led_o} !== 7'b0 ||
        y_buf_addr !== 32'd0 || y_buf_data !== 32'd0 || img_cnt_o !== 4'd0) begin
      errors++;
      $display("FAIL %s en=%b we=%b rdy=%b busy=%b err=%b intr=%b led=%b addr=%0d data=%08h img=%0d required all 0",
               name, y_buf_en, y_buf_wr_en, res_ready_o, busy_o, err_o, done_intr_o, done_led_o,
               y_buf_addr, y_buf_data, img_cnt_o);
    end
  endtask

  task automatic stream_clean(input int gap_pct);
    for (int w = 0; w < TOTAL; w++) begin
      if (gap_pct > 0) while ($urandom_range(0, 99) < gap_pct) idle(1);
      send_word(w, $urandom, (w % NC) == NC - 1);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_all_zero("reset_state");
  endtask

  task automatic test_full_stream();
    int base = strobes;
    done_cnt = 0;
    do_start();
    stream_clean(0);
    wait_drain(20);
    check_batch_end("full", base, 1'b0);
    checks++;
    if (last_wr_cyc - first_wr_cyc != TOTAL - 1) begin
      errors++;
      $display("FAIL back_to_back span=%0d required=%0d", last_wr_cyc - first_wr_cyc, TOTAL - 1);
    end
  endtask

  task automatic test_gaps();
    int base = strobes;
    done_cnt = 0;
    do_start();
    stream_clean(30);
    wait_drain(20);
    check_batch_end("gaps", base, 1'b0);
  endtask

  task automatic test_done_idle();
    int base = strobes;
    res_valid_i = 1'b1; res_data_i = 32'hdead_beef;
    for (int i = 0; i < 5; i++) begin
      sample();
      checks++;
      if (res_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL done_ready cyc=%0d got=%b required=0", i, res_ready_o);
      end
      adv();
    end
    res_valid_i = 1'b0;
    idle(2);
    checks++;
    if (strobes != base) begin
      errors++;
      $display("FAIL done_no_write strobes=%0d required=0", strobes - base);
    end
    do_start();
    for (int w = 0; w < 3; w++) send_word(w, 32'(100 + w), 1'b0);
    wait_drain(10);
    checks++;
    if (strobes - base != 3) begin
      errors++;
      $display("FAIL restart_writes got=%0d required=3", strobes - base);
    end
  endtask

  task automatic test_mid_reset();
    int base;
    do_reset();
    base = strobes;
    do_start();
    for (int w = 0; w < 37; w++) send_word(w, $urandom, (w % NC) == NC - 1);
    res_valid_i = 1'b1; res_data_i = 32'h1234_5678; rst_i = 1'b1;
    sample(); adv();
    rst_i = 1'b0; res_valid_i = 1'b0;
    check_all_zero("mid_reset");
    idle(5);
    checks++;
    if (strobes - base != 37 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL mid_reset_writes got=%0d pending=%0d required=37 pending=0", strobes - base, exp_q.size());
    end
    base = strobes;
    done_cnt = 0;
    do_start();
    stream_clean(0);
    wait_drain(20);
    check_batch_end("after_reset", base, 1'b0);
  endtask

  task automatic test_bad_last();
    int base = strobes;
    int cls = 0;
    logic last;
    done_cnt = 0;
    do_start();
    for (int w = 0; w < TOTAL; w++) begin
      last = (cls == NC - 1) || (w == 26);
      send_word(w, $urandom, last);
      cls = last ? 0 : cls + 1;
      if (w == 25) begin
        checks++;
        if (err_o !== 1'b0) begin errors++; $display("FAIL err_early got=%b required=0", err_o); end
      end
      if (w == 26) begin
        checks++;
        if (err_o !== 1'b1 || img_cnt_o !== 4'd3) begin
          errors++;
          $display("FAIL err_resync err=%b img=%0d required err=1 img=3", err_o, img_cnt_o);
        end
      end
    end
    wait_drain(20);
    check_batch_end("bad_last", base, 1'b1);
  endtask

`ifdef WB_ARGMAX_EN
  task automatic test_argmax();
    int vals[NC] = '{-5, 3, 9, 9, -1, 0, 2, 1, 8, 7};
    do_reset();
    do_start();
    for (int i = 0; i < NC; i++) begin
      send_word(i, 32'(vals[i]), i == NC - 1);
      if (i == NC - 2) begin
        checks++;
        if (pred_valid_o !== 1'b0) begin errors++; $display("FAIL pred_early got=%b required=0", pred_valid_o); end
      end
    end
    checks++;
    if (pred_valid_o !== 1'b1 || pred_o !== 4'd2 || y_buf_wr_en !== 1'b1 || y_buf_addr !== 32'd36) begin
      errors++;
      $display("FAIL argmax pv=%b pred=%0d we=%b addr=%0d required pv=1 pred=2 we=1 addr=36",
               pred_valid_o, pred_o, y_buf_wr_en, y_buf_addr);
    end
    for (int i = 0; i < NC; i++) send_word(NC + i, 32'd1, i == NC - 1);
    checks++;
    if (pred_valid_o !== 1'b1 || pred_o !== 4'd0) begin
      errors++;
      $display("FAIL argmax_tie pv=%b pred=%0d required pv=1 pred=0", pred_valid_o, pred_o);
    end
    wait_drain(10);
  endtask
`endif

  initial begin
    rst_i = 1'b1; start_i = 1'b0; res_valid_i = 1'b0; res_last_i = 1'b0; res_data_i = '0;
    test_reset();
    test_full_stream();
    test_gaps();
    test_done_idle();
    test_mid_reset();
    test_bad_last();
`ifdef WB_ARGMAX_EN
    test_argmax();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
